// File: rtl/timer_core_pkg.sv
// Shared types and default constants for the charge-duration timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CLK_HZ        = 1000;
  localparam int DEFAULT_TICKS = 10000;
  localparam int CNT_W         = 14;

endpackage

// File: rtl/timer_core_if.sv
// Request/status bundle between the payment control (master) and the timer (slave).
interface timer_core_if #(
  parameter int CNT_W = timer_pkg::CNT_W
);

  logic             start;
  logic             timing;
  logic [CNT_W-1:0] cnt;

  modport master (output start, input timing, input cnt);
  modport slave  (input start, output timing, output cnt);

endinterface

// File: rtl/timer_core.sv
// Single-shot charge timer: one run of TICKS cycles per start request,
// re-armed only after start has been released.
module timer_core
  import timer_pkg::*;
#(
  parameter int TICKS = DEFAULT_TICKS,
  parameter int CNT_W = timer_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  timer_core_if.slave bus
);

  localparam logic [CNT_W-1:0] TICKS_C = CNT_W'(TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (TICKS < 1 || TICKS >= (1 << CNT_W)) begin : g_bad_ticks
      $error("timer_core: TICKS=%0d does not fit 1..2^CNT_W-1 (CNT_W=%0d)", TICKS, CNT_W);
    end
  endgenerate

  state_t           r_state;
  logic             r_timing;
  logic [CNT_W-1:0] r_cnt;

  // The last RUN edge lands on DONE so a held start cannot retrigger.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_timing <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state  <= RUN;
            r_timing <= 1'b1;
            r_cnt    <= TICKS_C;
          end
        end
        RUN: begin
          if (r_cnt > CNT_ONE) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_cnt    <= '0;
            r_timing <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (!bus.start) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_timing <= 1'b0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.timing = r_timing;
  assign bus.cnt    = r_cnt;

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: default, TICKS=1 and TICKS=16383 instances
// checked against a queue of expected (timing, cnt) pairs.
module tb_timer_core;

  localparam int TICKS_A = 10000;
  localparam int TICKS_B = 1;
  localparam int TICKS_C = 16383;

  typedef struct {
    string       tag;
    logic        t;
    logic [13:0] c;
  } expect_t;

  logic clk;
  logic reset;

  int checkCount;
  int passCount;
  expect_t sbQueue[$];

  timer_core_if #(.CNT_W(14)) busA ();
  timer_core_if #(.CNT_W(14)) busB ();
  timer_core_if #(.CNT_W(14)) busC ();

  timer_core #(.TICKS(TICKS_A), .CNT_W(14)) dutA (.clk(clk), .reset(reset), .bus(busA));
  timer_core #(.TICKS(TICKS_B), .CNT_W(14)) dutB (.clk(clk), .reset(reset), .bus(busB));
  timer_core #(.TICKS(TICKS_C), .CNT_W(14)) dutC (.clk(clk), .reset(reset), .bus(busC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int sel, input logic startVal);
    case (sel)
      0:       busA.start = startVal;
      1:       busB.start = startVal;
      default: busC.start = startVal;
    endcase
  endtask

  task automatic pushExpect(input string tag, input logic expT, input int expC);
    expect_t e;
    e.tag = tag;
    e.t   = expT;
    e.c   = 14'(expC);
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input int sel);
    expect_t     e;
    logic        t;
    logic [13:0] c;
    case (sel)
      0:       begin t = busA.timing; c = busA.cnt; end
      1:       begin t = busB.timing; c = busB.cnt; end
      default: begin t = busC.timing; c = busC.cnt; end
    endcase
    checkCount++;
    if (sbQueue.size() == 0) begin
      $error("[TB] FAIL scoreboard_empty: observed timing=%0b cnt=%0d, expected an entry", t, c);
    end else begin
      e = sbQueue.pop_front();
      assert ({t, c} === {e.t, e.c}) passCount++;
      else $error("[TB] FAIL %s: observed timing=%0b cnt=%0d, expected timing=%0b cnt=%0d",
                  e.tag, t, c, e.t, e.c);
    end
  endtask

  task automatic cycleCheck(input int sel, input string tag, input logic expT, input int expC);
    pushExpect(tag, expT, expC);
    @(posedge clk);
    #1;
    checkOutput(sel);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    busA.start = 1'b1;
    busB.start = 1'b0;
    busC.start = 1'b0;

    // Async reset with start already requested: outputs clear before any edge.
    #2 reset = 1'b0;
    pushExpect("reset_async", 1'b0, 0);
    #1 checkOutput(0);
    for (int i = 0; i < 3; i++) cycleCheck(0, "reset_held", 1'b0, 0);

    // Release with start held: run begins on the first edge, then one run only.
    reset = 1'b1;
    for (int k = 0; k < TICKS_A; k++)
      cycleCheck(0, $sformatf("run1 k=%0d", k), 1'b1, TICKS_A - k);
    cycleCheck(0, "run1_end", 1'b0, 0);
    for (int i = 0; i < 20; i++) cycleCheck(0, "held_no_rerun", 1'b0, 0);

    applyStimulus(0, 1'b0);
    for (int i = 0; i < 5; i++) cycleCheck(0, "released_idle", 1'b0, 0);
    applyStimulus(0, 1'b1);

    // Second run with start toggling mid-run; start low as timing falls.
    for (int k = 0; k < TICKS_A; k++) begin
      cycleCheck(0, $sformatf("run2 k=%0d", k), 1'b1, TICKS_A - k);
      applyStimulus(0, (k % 3 == 0) && (k < TICKS_A - 2));
    end
    cycleCheck(0, "run2_end", 1'b0, 0);
    cycleCheck(0, "gap_idle", 1'b0, 0);
    applyStimulus(0, 1'b1);

    // Minimum gap re-arm; start pulsed for one cycle, then reset at cnt=4321.
    cycleCheck(0, "run3_start", 1'b1, TICKS_A);
    applyStimulus(0, 1'b0);
    for (int v = TICKS_A - 1; v >= 4321; v--)
      cycleCheck(0, $sformatf("run3 cnt=%0d", v), 1'b1, v);
    #2 reset = 1'b0;
    pushExpect("reset_midrun_async", 1'b0, 0);
    #1 checkOutput(0);
    cycleCheck(0, "reset_midrun_held", 1'b0, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cycleCheck(0, "after_reset_idle", 1'b0, 0);

    // TICKS=1 instance.
    applyStimulus(1, 1'b1);
    cycleCheck(1, "t1_run", 1'b1, 1);
    cycleCheck(1, "t1_end", 1'b0, 0);
    cycleCheck(1, "t1_held", 1'b0, 0);
    applyStimulus(1, 1'b0);
    cycleCheck(1, "t1_idle", 1'b0, 0);
    applyStimulus(1, 1'b1);
    cycleCheck(1, "t1_rerun", 1'b1, 1);
    cycleCheck(1, "t1_rerun_end", 1'b0, 0);

    // TICKS=16383 instance: full-width count with no overflow.
    applyStimulus(2, 1'b1);
    for (int k = 0; k < TICKS_C; k++)
      cycleCheck(2, $sformatf("tmax k=%0d", k), 1'b1, TICKS_C - k);
    cycleCheck(2, "tmax_end", 1'b0, 0);
    cycleCheck(2, "tmax_held", 1'b0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
